// File: rtl/id_control_issue.sv
// Decode/issue control: MIPS opcode/funct -> registered EX control bundle with
// load-use interlock, stall/flush handling and optional jump squash (JUMP_SQUASH_EN).
module id_control_issue (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       stall,
    input  logic       flush,
    output logic       RegDst,
    output logic [3:0] ALUOp,
    output logic       ALUSrc,
    output logic [1:0] Jump,
    output logic       issue_valid,
    output logic       illegal
);
    localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2,
                           OP_OR  = 4'h3, OP_SLT = 4'h4, OP_XOR = 4'h5;

`ifdef JUMP_SQUASH_EN
    typedef enum logic {ST_ISSUE, ST_SQUASH} state_t;
    state_t r_state, w_state_nxt;
`endif

    logic       r_regdst, r_alusrc, r_vld, r_illegal, r_ld_vld;
    logic [3:0] r_aluop;
    logic [1:0] r_jump;
    logic [4:0] r_ld_rt;

    logic       w_regdst, w_alusrc, w_vld, w_illegal, w_ld_vld;
    logic [3:0] w_aluop;
    logic [1:0] w_jump;
    logic [4:0] w_ld_rt;

    logic       w_dec_ok, w_dec_lw, w_dec_regdst, w_dec_alusrc, w_hazard;
    logic [3:0] w_dec_aluop;
    logic [1:0] w_dec_jump;

    always_comb begin
        w_dec_ok     = 1'b1;
        w_dec_lw     = 1'b0;
        w_dec_regdst = 1'b0;
        w_dec_alusrc = 1'b0;
        w_dec_aluop  = OP_ADD;
        w_dec_jump   = 2'b00;
        case (opcode)
            6'h00: begin
                w_dec_regdst = 1'b1;
                case (funct)
                    6'h20: w_dec_aluop = OP_ADD;
                    6'h22: w_dec_aluop = OP_SUB;
                    6'h24: w_dec_aluop = OP_AND;
                    6'h25: w_dec_aluop = OP_OR;
                    6'h2A: w_dec_aluop = OP_SLT;
                    6'h26: w_dec_aluop = OP_XOR;
                    6'h08: begin
                        w_dec_regdst = 1'b0;
                        w_dec_jump   = 2'b11;
                    end
                    default: w_dec_ok = 1'b0;
                endcase
            end
            6'h23: begin w_dec_alusrc = 1'b1; w_dec_lw = 1'b1; end
            6'h2B: w_dec_alusrc = 1'b1;
            6'h08: w_dec_alusrc = 1'b1;
            6'h0C: begin w_dec_alusrc = 1'b1; w_dec_aluop = OP_AND; end
            6'h0D: begin w_dec_alusrc = 1'b1; w_dec_aluop = OP_OR;  end
            6'h0A: begin w_dec_alusrc = 1'b1; w_dec_aluop = OP_SLT; end
            6'h04: w_dec_aluop = OP_SUB;
            6'h02: w_dec_jump  = 2'b01;
            6'h03: w_dec_jump  = 2'b10;
            default: w_dec_ok = 1'b0;
        endcase
    end

    // Only a tracked load with a nonzero destination can create a hazard ($0 never changes).
    assign w_hazard = r_ld_vld && (r_ld_rt != 5'd0) && in_valid &&
                      ((rs == r_ld_rt) || (rt == r_ld_rt));

    always_comb begin
        in_ready  = 1'b0;
        w_regdst  = 1'b0;
        w_aluop   = OP_ADD;
        w_alusrc  = 1'b0;
        w_jump    = 2'b00;
        w_vld     = 1'b0;
        w_illegal = 1'b0;
        w_ld_vld  = 1'b0;
        w_ld_rt   = 5'd0;
`ifdef JUMP_SQUASH_EN
        w_state_nxt = r_state;
`endif
        if (rst) begin
            in_ready = 1'b0;
        end else if (flush) begin
            in_ready = 1'b1;
`ifdef JUMP_SQUASH_EN
            w_state_nxt = ST_ISSUE;
`endif
        end else if (stall) begin
            w_regdst = r_regdst;
            w_aluop  = r_aluop;
            w_alusrc = r_alusrc;
            w_jump   = r_jump;
            w_vld    = r_vld;
            w_ld_vld = r_ld_vld;
            w_ld_rt  = r_ld_rt;
        end else if (w_hazard) begin
            in_ready = 1'b0;
`ifdef JUMP_SQUASH_EN
        end else if (r_state == ST_SQUASH) begin
            if (in_valid) begin
                in_ready    = 1'b1;
                w_state_nxt = ST_ISSUE;
            end
`endif
        end else if (in_valid) begin
            in_ready = 1'b1;
            if (w_dec_ok) begin
                w_regdst = w_dec_regdst;
                w_aluop  = w_dec_aluop;
                w_alusrc = w_dec_alusrc;
                w_jump   = w_dec_jump;
                w_vld    = 1'b1;
                w_ld_vld = w_dec_lw;
                w_ld_rt  = w_dec_lw ? rt : 5'd0;
`ifdef JUMP_SQUASH_EN
                if (w_dec_jump != 2'b00) w_state_nxt = ST_SQUASH;
`endif
            end else begin
                w_illegal = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_regdst  <= 1'b0;
            r_aluop   <= OP_ADD;
            r_alusrc  <= 1'b0;
            r_jump    <= 2'b00;
            r_vld     <= 1'b0;
            r_illegal <= 1'b0;
            r_ld_vld  <= 1'b0;
            r_ld_rt   <= 5'd0;
        end else begin
            r_regdst  <= w_regdst;
            r_aluop   <= w_aluop;
            r_alusrc  <= w_alusrc;
            r_jump    <= w_jump;
            r_vld     <= w_vld;
            r_illegal <= w_illegal;
            r_ld_vld  <= w_ld_vld;
            r_ld_rt   <= w_ld_rt;
        end
    end

`ifdef JUMP_SQUASH_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_ISSUE;
        else     r_state <= w_state_nxt;
    end
`endif

    assign RegDst      = r_regdst;
    assign ALUOp       = r_aluop;
    assign ALUSrc      = r_alusrc;
    assign Jump        = r_jump;
    assign issue_valid = r_vld;
    assign illegal     = r_illegal;
endmodule

// File: tb/tb_id_control_issue.sv
// Directed bench for id_control_issue; bundle packed as
// {issue_valid, illegal, RegDst, ALUOp[3:0], ALUSrc, Jump[1:0]}.
module tb_id_control_issue;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0, in_ready;
    logic [5:0] opcode = '0, funct = '0;
    logic [4:0] rs = '0, rt = '0;
    logic       stall = 1'b0, flush = 1'b0;
    logic       RegDst, ALUSrc, issue_valid, illegal;
    logic [3:0] ALUOp;
    logic [1:0] Jump;

    int checks = 0;
    int errors = 0;

    id_control_issue dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct(funct), .rs(rs), .rt(rt),
        .stall(stall), .flush(flush),
        .RegDst(RegDst), .ALUOp(ALUOp), .ALUSrc(ALUSrc), .Jump(Jump),
        .issue_valid(issue_valid), .illegal(illegal)
    );

    always #5 clk = ~clk;

    localparam logic [9:0] BUB   = 10'b0_0_0_0000_0_00;
    localparam logic [9:0] B_LW  = 10'b1_0_0_0000_1_00;
    localparam logic [9:0] B_ADD = 10'b1_0_1_0000_0_00;
    localparam logic [9:0] B_SUB = 10'b1_0_1_0001_0_00;
    localparam logic [9:0] B_XOR = 10'b1_0_1_0101_0_00;
    localparam logic [9:0] B_ORI = 10'b1_0_0_0011_1_00;
    localparam logic [9:0] B_ANDI= 10'b1_0_0_0010_1_00;
    localparam logic [9:0] B_SLTI= 10'b1_0_0_0100_1_00;
    localparam logic [9:0] B_ADDI= 10'b1_0_0_0000_1_00;
    localparam logic [9:0] B_BEQ = 10'b1_0_0_0001_0_00;
    localparam logic [9:0] B_J   = 10'b1_0_0_0000_0_01;
    localparam logic [9:0] B_JAL = 10'b1_0_0_0000_0_10;
    localparam logic [9:0] B_JR  = 10'b1_0_0_0000_0_11;
    localparam logic [9:0] B_ILL = 10'b0_1_0_0000_0_00;

    function automatic logic [9:0] bundle();
        return {issue_valid, illegal, RegDst, ALUOp, ALUSrc, Jump};
    endfunction

    task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] s, input logic [4:0] t);
        in_valid = v; opcode = op; funct = fn; rs = s; rt = t;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state, in_ready low during reset even with a valid instruction
        drv(1, 6'h23, 6'h00, 5'd1, 5'd5);
        tick();
        chk("rst_bundle", bundle(), BUB);
        chk("rst_ready", {9'd0, in_ready}, 10'd0);
        rst = 1'b0;
        #1;
        chk("lw_ready", {9'd0, in_ready}, 10'd1);
        tick();
        chk("lw_issue", bundle(), B_LW);

        // load-use hazard on rs
        drv(1, 6'h00, 6'h20, 5'd5, 5'd6);
        chk("haz_ready", {9'd0, in_ready}, 10'd0);
        tick();
        chk("haz_bubble", bundle(), BUB);
        chk("haz_ready2", {9'd0, in_ready}, 10'd1);
        tick();
        chk("haz_add", bundle(), B_ADD);

        // load to $0 never stalls
        drv(1, 6'h23, 6'h00, 5'd2, 5'd0);
        tick();
        chk("lw0_issue", bundle(), B_LW);
        drv(1, 6'h00, 6'h20, 5'd0, 5'd0);
        chk("lw0_ready", {9'd0, in_ready}, 10'd1);
        tick();
        chk("lw0_add", bundle(), B_ADD);

        // hazard via rt match
        drv(1, 6'h23, 6'h00, 5'd1, 5'd9);
        tick();
        drv(1, 6'h04, 6'h00, 5'd3, 5'd9);
        chk("haz_rt_ready", {9'd0, in_ready}, 10'd1 ^ 10'd1);
        tick();
        chk("haz_rt_bubble", bundle(), BUB);
        tick();
        chk("beq_issue", bundle(), B_BEQ);

        // stall freezes outputs with ori pending
        drv(1, 6'h00, 6'h22, 5'd1, 5'd2);
        tick();
        chk("sub_issue", bundle(), B_SUB);
        drv(1, 6'h0D, 6'h00, 5'd1, 5'd2);
        stall = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("stall_ready", {9'd0, in_ready}, 10'd0);
            tick();
            chk("stall_hold", bundle(), B_SUB);
        end
        stall = 1'b0;
        #1;
        chk("unstall_ready", {9'd0, in_ready}, 10'd1);
        tick();
        chk("ori_issue", bundle(), B_ORI);

        // flush beats stall; sub discarded
        drv(1, 6'h00, 6'h22, 5'd1, 5'd2);
        flush = 1'b1; stall = 1'b1;
        #1;
        chk("flush_ready", {9'd0, in_ready}, 10'd1);
        tick();
        chk("flush_bubble", bundle(), BUB);
        flush = 1'b0; stall = 1'b0;
        drv(0, 6'h00, 6'h22, 5'd1, 5'd2);
        chk("idle_ready", {9'd0, in_ready}, 10'd0);
        tick();
        chk("flush_no_sub", bundle(), BUB);

        // jump followed by addi
        drv(1, 6'h02, 6'h00, 5'd0, 5'd0);
        tick();
        chk("j_issue", bundle(), B_J);
        drv(1, 6'h08, 6'h00, 5'd1, 5'd3);
        chk("addi_ready", {9'd0, in_ready}, 10'd1);
        tick();
`ifdef JUMP_SQUASH_EN
        chk("addi_squash", bundle(), BUB);
`else
        chk("addi_delay", bundle(), B_ADDI);
`endif

        // illegal opcode, one-cycle pulse
        drv(1, 6'h3F, 6'h00, 5'd0, 5'd0);
        tick();
        chk("ill_op", bundle(), B_ILL);
        drv(0, 6'h00, 6'h00, 5'd0, 5'd0);
        tick();
        chk("ill_clear", bundle(), BUB);
        drv(1, 6'h00, 6'h3F, 5'd0, 5'd0);
        tick();
        chk("ill_funct", bundle(), B_ILL);

        // remaining decodes
        drv(1, 6'h00, 6'h26, 5'd1, 5'd2);
        tick();
        chk("xor_issue", bundle(), B_XOR);
        drv(1, 6'h0A, 6'h00, 5'd1, 5'd2);
        tick();
        chk("slti_issue", bundle(), B_SLTI);
        drv(1, 6'h03, 6'h00, 5'd0, 5'd0);
        tick();
        chk("jal_issue", bundle(), B_JAL);
        drv(0, 6'h00, 6'h00, 5'd0, 5'd0);
        tick();
`ifdef JUMP_SQUASH_EN
        drv(1, 6'h00, 6'h00, 5'd0, 5'd0);
        tick();
`endif
        drv(1, 6'h00, 6'h08, 5'd31, 5'd0);
        tick();
        chk("jr_issue", bundle(), B_JR);

        // async reset mid-stall clears without a clock edge
        drv(1, 6'h0C, 6'h00, 5'd1, 5'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        tick();
        chk("andi_issue", bundle(), B_ANDI);
        stall = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_bundle", bundle(), BUB);
        chk("arst_ready", {9'd0, in_ready}, 10'd0);
        tick();
        stall = 1'b0;
        drv(1, 6'h23, 6'h00, 5'd1, 5'd4);
        rst = 1'b0;
        #1;
        tick();
        chk("post_rst_lw", bundle(), B_LW);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end
endmodule
